// File: rtl/bram_pingpong_arbiter.sv
// Purpose : shares the low/high weight BRAM banks between the stream loader (A)
//           and the compute reader (B); owns the ping-pong mapping (weight_switch).
// Latency : read accepted at edge t -> rvalid/rdata in cycle t+2+RD_LAT; fixed, no bubbles.
// Backpr. : combinational ready per requester; no backpressure on read responses.
// Ports   : a_*/b_* requester ports (valid/ready/we/bank/addr/wdata, rvalid/rdata),
//           swap_req/swap_ack/weight_switch bank-swap handshake,
//           addr/din/we/dout _l and _h BRAM primitive ports.
module bram_pingpong_arbiter #(
  parameter int AW     = 14,
  parameter int DW     = 128,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_we,
  input  logic          a_bank,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_we,
  input  logic          b_bank,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  input  logic          swap_req,
  output logic          swap_ack,
  output logic          weight_switch,
  output logic [AW-1:0] addr_l,
  output logic [DW-1:0] din_l,
  output logic          we_l,
  input  logic [DW-1:0] dout_l,
  output logic [AW-1:0] addr_h,
  output logic [DW-1:0] din_h,
  output logic          we_h,
  input  logic [DW-1:0] dout_h
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Per physical bank (index 0 = l, 1 = h): 0 = A has priority, 1 = B.
  logic [1:0]    prio;
  logic          a_phys, b_phys, contested;
  logic          a_gnt, b_gnt;

  // Request steered onto each physical bank this cycle.
  logic [1:0]    bank_gnt, bank_id, bank_we;
  logic [AW-1:0] bank_addr [2];
  logic [DW-1:0] bank_din  [2];

  // Read tags per bank: stage k corresponds to k+1 cycles after acceptance.
  logic [RD_LAT:0] tag_vld [2];
  logic [RD_LAT:0] tag_id  [2];
  logic            in_flight;
  logic [1:0]      out_a, out_b;

  // Arbitration: only IDLE grants; a contested bank goes to its priority side.
  always_comb begin
    a_phys    = a_bank ^ weight_switch;
    b_phys    = b_bank ^ weight_switch;
    contested = a_valid & b_valid & (a_phys == b_phys);
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    if (rst_n && state == IDLE) begin
      a_gnt = a_valid & (~contested | ~prio[a_phys]);
      b_gnt = b_valid & (~contested |  prio[b_phys]);
    end
  end

  assign a_ready = a_gnt;
  assign b_ready = b_gnt;

  // Steer each granted request onto its physical bank.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      bank_gnt[k]  = 1'b0;
      bank_id[k]   = 1'b0;
      bank_we[k]   = 1'b0;
      bank_addr[k] = a_addr;
      bank_din[k]  = a_wdata;
      if (a_gnt && a_phys == 1'(k)) begin
        bank_gnt[k] = 1'b1;
        bank_we[k]  = a_we;
      end else if (b_gnt && b_phys == 1'(k)) begin
        bank_gnt[k]  = 1'b1;
        bank_id[k]   = 1'b1;
        bank_we[k]   = b_we;
        bank_addr[k] = b_addr;
        bank_din[k]  = b_wdata;
      end
    end
  end

  assign in_flight = (|tag_vld[0]) | (|tag_vld[1]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (swap_req)   state_nxt = DRAIN;
      DRAIN:   if (!in_flight) state_nxt = SWAP;
      SWAP:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  assign swap_ack = (state == SWAP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      weight_switch <= 1'b0;
      prio          <= 2'b00;
    end else begin
      state <= state_nxt;
      if (state == SWAP) weight_switch <= ~weight_switch;
      // Winner of a contested bank hands priority to the loser.
      if (contested && state == IDLE) prio[a_phys] <= a_gnt;
    end
  end

  // BRAM ports: addr/din hold when idle, we is a single-cycle strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_l <= '0;
      din_l  <= '0;
      we_l   <= 1'b0;
      addr_h <= '0;
      din_h  <= '0;
      we_h   <= 1'b0;
    end else begin
      we_l <= bank_gnt[0] & bank_we[0];
      we_h <= bank_gnt[1] & bank_we[1];
      if (bank_gnt[0]) begin
        addr_l <= bank_addr[0];
        din_l  <= bank_din[0];
      end
      if (bank_gnt[1]) begin
        addr_h <= bank_addr[1];
        din_h  <= bank_din[1];
      end
    end
  end

  // Tag pipelines; writes enter as empty slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        tag_vld[k] <= '0;
        tag_id[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        tag_vld[k] <= {tag_vld[k][RD_LAT-1:0], bank_gnt[k] & ~bank_we[k]};
        tag_id[k]  <= {tag_id[k][RD_LAT-1:0], bank_id[k]};
      end
    end
  end

  // Output-stage ownership per bank. A requester holds at most one grant per
  // cycle, so at most one bank can complete for it in any cycle.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      out_a[k] = tag_vld[k][RD_LAT] & ~tag_id[k][RD_LAT];
      out_b[k] = tag_vld[k][RD_LAT] &  tag_id[k][RD_LAT];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= |out_a;
      b_rvalid <= |out_b;
      if (out_a[0])      a_rdata <= dout_l;
      else if (out_a[1]) a_rdata <= dout_h;
      if (out_b[0])      b_rdata <= dout_l;
      else if (out_b[1]) b_rdata <= dout_h;
    end
  end

endmodule

// File: tb/tb_bram_pingpong_arbiter.sv
// Purpose : self-checking bench for bram_pingpong_arbiter with a BRAM model,
//           a reference model of grants/swap and a response scoreboard.
// Ports   : none (top-level bench).
module tb_bram_pingpong_arbiter;
  localparam int AW     = 14;
  localparam int DW     = 128;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, a_ready, a_we, a_bank, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_valid, b_ready, b_we, b_bank, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          swap_req, swap_ack, weight_switch;
  logic [AW-1:0] addr_l, addr_h;
  logic [DW-1:0] din_l, din_h, dout_l, dout_h;
  logic          we_l, we_h;

  bram_pingpong_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_bank(a_bank),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_bank(b_bank),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .swap_req(swap_req), .swap_ack(swap_ack), .weight_switch(weight_switch),
    .addr_l(addr_l), .din_l(din_l), .we_l(we_l), .dout_l(dout_l),
    .addr_h(addr_h), .din_h(din_h), .we_h(we_h), .dout_h(dout_h)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int b, input int a);
    return {32'(a) ^ 32'h5A5A_0000, 32'(b) + 32'h1111_0000, 32'(a * 7 + b), 32'hC0DE_0000 ^ 32'(a << 1)};
  endfunction

  // ---------------- BRAM model (environment) ----------------
  logic [DW-1:0] bram_l [int];
  logic [DW-1:0] bram_h [int];
  logic [DW-1:0] pipe_l [RD_LAT];
  logic [DW-1:0] pipe_h [RD_LAT];

  always @(posedge clk) begin
    logic [DW-1:0] rl, rh;
    rl = bram_l.exists(int'(addr_l)) ? bram_l[int'(addr_l)] : init_word(0, int'(addr_l));
    rh = bram_h.exists(int'(addr_h)) ? bram_h[int'(addr_h)] : init_word(1, int'(addr_h));
    if (we_l) bram_l[int'(addr_l)] = din_l;
    if (we_h) bram_h[int'(addr_h)] = din_h;
    pipe_l[0] <= rl;
    pipe_h[0] <= rh;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_l[i] <= pipe_l[i-1];
      pipe_h[i] <= pipe_h[i-1];
    end
  end
  assign dout_l = pipe_l[RD_LAT-1];
  assign dout_h = pipe_h[RD_LAT-1];

  // ---------------- Reference model ----------------
  logic [DW-1:0] sh_l [int];
  logic [DW-1:0] sh_h [int];

  function automatic logic [DW-1:0] sh_rd(input logic b, input int a);
    if (b) return sh_h.exists(a) ? sh_h[a] : init_word(1, a);
    return sh_l.exists(a) ? sh_l[a] : init_word(0, a);
  endfunction

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } resp_t;
  resp_t qa[$];
  resp_t qb[$];

  int            m_state;     // 0 idle, 1 draining, 2 swapping
  logic          m_ws;
  logic [1:0]    m_prio;      // per physical bank: 0 = A first, 1 = B first
  int            m_last_due;  // latest cycle a read response is due
  logic [1:0]    exp_we, exp_chk, new_we, new_chk;
  logic [AW-1:0] exp_addr [2];
  logic [AW-1:0] new_addr [2];
  logic [DW-1:0] exp_din  [2];
  logic [DW-1:0] new_din  [2];

  task automatic model_reset();
    m_state = 0; m_ws = 1'b0; m_prio = 2'b00; m_last_due = 0;
    exp_we = 2'b00; exp_chk = 2'b00;
    qa.delete(); qb.delete();
  endtask

  task automatic accept(input logic side, input logic p, input logic we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data);
    resp_t r;
    new_chk[p] = 1'b1; new_we[p] = we; new_addr[p] = addr; new_din[p] = data;
    if (we) begin
      if (p) sh_h[int'(addr)] = data; else sh_l[int'(addr)] = data;
    end else begin
      r.data = sh_rd(p, int'(addr));
      r.due  = cyc + RD_LAT + 2;
      if (m_last_due < r.due) m_last_due = r.due;
      if (side) qb.push_back(r); else qa.push_back(r);
    end
  endtask

  // One clock: evaluate and check at negedge, advance past the next posedge.
  task automatic step();
    logic pa, pb, ga, gb, cont;
    @(negedge clk);
    if (!rst_n) begin
      @(posedge clk);
      model_reset();
      #1;
      return;
    end
    pa = a_bank ^ m_ws;
    pb = b_bank ^ m_ws;
    cont = a_valid & b_valid & (pa == pb);
    ga = 1'b0; gb = 1'b0;
    if (m_state == 0) begin
      if (cont) begin
        if (m_prio[pa]) gb = 1'b1; else ga = 1'b1;
      end else begin
        ga = a_valid; gb = b_valid;
      end
    end
    check("a_ready", a_ready, ga);
    check("b_ready", b_ready, gb);
    check("swap_ack", swap_ack, m_state == 2);
    check("weight_switch", weight_switch, m_ws);
    check("we_l", we_l, exp_we[0]);
    check("we_h", we_h, exp_we[1]);
    if (exp_chk[0]) check("addr_l", addr_l, exp_addr[0]);
    if (exp_chk[1]) check("addr_h", addr_h, exp_addr[1]);
    if (exp_we[0])  check("din_l", din_l, exp_din[0]);
    if (exp_we[1])  check("din_h", din_h, exp_din[1]);
    new_we = 2'b00; new_chk = 2'b00;
    if (ga) accept(1'b0, pa, a_we, a_addr, a_wdata);
    if (gb) accept(1'b1, pb, b_we, b_addr, b_wdata);
    if (cont && m_state == 0) m_prio[pa] = ga;
    case (m_state)
      0: if (swap_req) m_state = 1;
      1: if (m_last_due <= cyc) m_state = 2;
      default: begin m_state = 0; m_ws = ~m_ws; end
    endcase
    @(posedge clk);
    #1;
    if (ga) a_valid = 1'b0;
    if (gb) b_valid = 1'b0;
    exp_we = new_we; exp_chk = new_chk;
    exp_addr = new_addr; exp_din = new_din;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_a(input logic we, input logic bank, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    a_valid = 1'b1; a_we = we; a_bank = bank; a_addr = addr; a_wdata = data;
  endtask

  task automatic set_b(input logic we, input logic bank, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    b_valid = 1'b1; b_we = we; b_bank = bank; b_addr = addr; b_wdata = data;
  endtask

  task automatic check_reset_vals();
    check("rst a_ready", a_ready, 0);
    check("rst b_ready", b_ready, 0);
    check("rst a_rvalid", a_rvalid, 0);
    check("rst b_rvalid", b_rvalid, 0);
    check("rst swap_ack", swap_ack, 0);
    check("rst we_l", we_l, 0);
    check("rst we_h", we_h, 0);
    check("rst addr_l", addr_l, 0);
    check("rst addr_h", addr_h, 0);
    check("rst din_l", din_l, 0);
    check("rst din_h", din_h, 0);
    check("rst a_rdata", a_rdata, 0);
    check("rst b_rdata", b_rdata, 0);
    check("rst weight_switch", weight_switch, 0);
  endtask

  // ---------------- Response monitor ----------------
  resp_t mr;
  initial begin
    forever begin
      @(negedge clk);
      if (a_rvalid) begin
        if (qa.size() == 0) begin
          errors++; checks++;
          $display("FAIL a_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          mr = qa.pop_front();
          check("a_rdata", a_rdata, mr.data);
          check("a_rvalid_cycle", DW'(cyc), DW'(mr.due));
        end
      end else if (qa.size() > 0 && qa[0].due <= cyc) begin
        mr = qa.pop_front();
        check("a_rvalid_missing", a_rvalid, 1);
      end
      if (b_rvalid) begin
        if (qb.size() == 0) begin
          errors++; checks++;
          $display("FAIL b_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          mr = qb.pop_front();
          check("b_rdata", b_rdata, mr.data);
          check("b_rvalid_cycle", DW'(cyc), DW'(mr.due));
        end
      end else if (qb.size() > 0 && qb[0].due <= cyc) begin
        mr = qb.pop_front();
        check("b_rvalid_missing", b_rvalid, 1);
      end
    end
  end

  // ---------------- Stimulus ----------------
  initial begin
    rst_n = 1'b0; swap_req = 1'b0;
    a_valid = 1'b0; a_we = 1'b0; a_bank = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_we = 1'b0; b_bank = 1'b0; b_addr = '0; b_wdata = '0;
    model_reset();
    bram_l[16] = {16{8'hAA}};
    sh_l[16]   = {16{8'hAA}};
    run_idle(2);
    rst_n = 1'b1;
    check_reset_vals();

    // A reads l@0x0010.
    set_a(1'b0, 1'b0, 14'h0010, '0);
    run_idle(7);

    // A writes bank0@0x3FFF while B reads bank1@0x0000, then read-back.
    set_a(1'b1, 1'b0, 14'h3FFF, 128'h1234);
    set_b(1'b0, 1'b1, 14'h0000, '0);
    run_idle(3);
    set_a(1'b0, 1'b0, 14'h3FFF, '0);
    run_idle(6);

    // Both requesters contend for bank0.
    for (int i = 0; i < 4; i++) begin
      if (!a_valid) set_a(1'b0, 1'b0, 14'(64 + i), '0);
      if (!b_valid) set_b(1'b0, 1'b0, 14'(80 + i), '0);
      step();
    end
    run_idle(8);

    // 8 back-to-back B reads, swap, then A logical bank0 under the new mapping.
    for (int i = 0; i < 8; i++) begin
      set_b(1'b0, 1'b0, 14'(32 + i), '0);
      step();
    end
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    set_a(1'b0, 1'b0, 14'h0005, '0);
    run_idle(12);

    // Idle swap with swap_req held into DRAIN.
    swap_req = 1'b1;
    run_idle(2);
    swap_req = 1'b0;
    run_idle(5);

    // Randomised traffic with occasional swaps.
    for (int i = 0; i < 600; i++) begin
      if (!a_valid && $urandom_range(0, 3) != 0)
        set_a(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 14'(16383 - $urandom_range(0, 3)) : 14'($urandom_range(0, 15)),
              {$urandom, $urandom, $urandom, $urandom});
      if (!b_valid && $urandom_range(0, 3) != 0)
        set_b(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 14'(16383 - $urandom_range(0, 3)) : 14'($urandom_range(0, 15)),
              {$urandom, $urandom, $urandom, $urandom});
      swap_req = ($urandom_range(0, 19) == 0);
      step();
    end
    swap_req = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    run_idle(12);

    // Reset with two reads in flight and a swap pending.
    set_a(1'b0, 1'b0, 14'h0001, '0);
    step();
    set_b(1'b0, 1'b1, 14'h0002, '0);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset_vals();
    run_idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_pingpong_arbiter.md
# bram_pingpong_arbiter

Shares the two 128-bit weight BRAM banks (low and high, 14-bit address each) between two requesters: the stream loader (port A) and the compute-side reader (port B). Arbitrates per bank each cycle and routes read data back to the issuing requester with fixed latency. Owns the ping-pong bank mapping and the `weight_switch` flag, swapping banks only after all in-flight reads have drained. Sits between the stream interface / systolic engine and the BRAM primitives.

## Interface
- AW, 14, BRAM address width
- DW, 128, BRAM data width
- RD_LAT, 2, BRAM read latency in clocks from address-present cycle to dout valid (1..4)

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- a_valid / b_valid  in  1  request valid, per requester
- a_ready / b_ready  out  1  request accepted this cycle (combinational grant)
- a_we / b_we  in  1  1 = write, 0 = read
- a_bank / b_bank  in  1  logical bank; physical bank = bank ^ weight_switch (0 = l, 1 = h)
- a_addr / b_addr  in  AW  word address
- a_wdata / b_wdata  in  DW  write data
- a_rvalid / b_rvalid  out  1  read data valid, one-cycle pulse; no backpressure
- a_rdata / b_rdata  out  DW  read data
- swap_req  in  1  request bank swap, sampled in IDLE
- swap_ack  out  1  one-cycle pulse when swap is performed
- weight_switch  out  1  current bank mapping
- addr_l, din_l, we_l  out  AW, DW, 1  low bank port
- dout_l  in  DW  low bank read data
- addr_h, din_h, we_h  out  AW, DW, 1  high bank port
- dout_h  in  DW  high bank read data

## Operation
- FSM states: IDLE, DRAIN, SWAP.
  - IDLE → DRAIN when swap_req = 1.
  - DRAIN → SWAP when no reads are in flight on either bank.
  - SWAP → IDLE unconditionally. SWAP toggles weight_switch and pulses swap_ack.
- a_ready and b_ready are forced to 0 in DRAIN and SWAP.
- swap_req is ignored outside IDLE. If swap_req is held high, each IDLE cycle starts a new swap.
- Per-bank arbitration in IDLE:
  - Requesters targeting different physical banks are both granted in the same cycle.
  - When both target the same bank, the grant goes to the side named by that bank's priority bit.
  - The priority bit flips to the losing side after each contested grant. It is unchanged on uncontested grants.
  - Both priority bits reset to A.
- Granted request: addr/din/we of the target bank are registered from the request.
  - A bank with no grant drives we = 0. addr and din hold their last values.
- Read tracking: per-bank shift register of RD_LAT+1 stages holding {valid, requester id}.
  - At the output stage, dout of that bank is registered into the owning requester's rdata and rvalid is pulsed.
  - Writes create no tag and no response.
- A requester receives at most one response per cycle, because it holds at most one grant per cycle.
- In-flight = OR of all tag valid bits in both banks.

## Timing
- Reset values:
  - a_ready, b_ready, a_rvalid, b_rvalid, swap_ack, we_l, we_h = 0.
  - addr_l, addr_h = 0. din_l, din_h, a_rdata, b_rdata = 0.
  - weight_switch = 0, FSM = IDLE, all tags cleared.
- Request accepted at edge t (valid & ready):
  - BRAM addr/we driven during cycle t+1.
  - dout sampled at end of cycle t+1+RD_LAT.
  - rvalid/rdata high in cycle t+2+RD_LAT.
  - Latency is fixed, with no bubbles: back-to-back reads give back-to-back rvalid.
- Write accepted at edge t: we = 1 during cycle t+1 only.
- A read issued after a write to the same address in a later cycle returns the new data.
- DRAIN with no in-flight reads lasts 1 cycle. In the SWAP cycle, swap_ack = 1. The new weight_switch is visible from the cycle after SWAP, together with restored readiness.
- A request held valid during DRAIN/SWAP stays pending and is granted in the first IDLE cycle, using the new mapping.
- Reset mid-operation: tags are flushed, in-flight responses are dropped, and a pending swap is abandoned.

## Test plan
- Reset, then A reads l@0x0010 while the BRAM model returns 0xAA…AA (RD_LAT = 2) → a_rvalid exactly 4 cycles after accept with 0xAA…AA; b_rvalid stays 0.
- A writes bank0@0x3FFF = 0x1234 while B reads bank1@0x0000 in the same cycle → both ready = 1; we_l = 1 with addr_l = 0x3FFF; addr_h = 0; only b_rvalid pulses.
- A and B both hold reads to bank0 for 4 cycles → grants alternate A, B, A, B; responses return in that order on the correct port.
- 8 back-to-back B reads, then swap_req → ready stays 0 until the last b_rvalid, then one SWAP cycle with swap_ack = 1; weight_switch = 1; a logical bank0 read now drives addr_h.
- swap_req while idle with no traffic → swap_ack exactly 2 cycles after swap_req is sampled; swap_req asserted during DRAIN causes no second swap.
- rst_n low for 1 cycle with 2 reads in flight → no rvalid afterwards; weight_switch = 0; all outputs at reset values.
